// File: rtl/tff_bank_rr_sched_if.sv
// Requester-side bus of the toggle-bank scheduler.
//
// Handshake: req[i] is a level request that, together with its req_sel
// field, is held stable until grant[i] is seen high. grant is a registered
// one-cycle pulse. req_sel is captured at the arbitration edge. A requester
// drops req[i] in its grant cycle. A req[i] still high in the following
// cycle is a fresh request.
interface tff_bank_rr_sched_if #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = 3
);
    logic                   en;
    logic [NREQ-1:0]        req;
    logic [NREQ*IDXW-1:0]   req_sel;
    logic [NREQ-1:0]        grant;
    logic [NBITS-1:0]       t_pulse;
    logic [NBITS-1:0]       q;
    logic [15:0]            toggle_cnt;
    logic                   err;

    modport master (
        output en, req, req_sel,
        input  grant, t_pulse, q, toggle_cnt, err
    );

    modport slave (
        input  en, req, req_sel,
        output grant, t_pulse, q, toggle_cnt, err
    );
endinterface

// File: rtl/tff_bank_rr_sched.sv
// Round-robin sequencer that shares a bank of toggle flip-flops between
// several requesters. Each grant drives one T strobe into the bank and
// bumps a saturating toggle counter. A select outside the bank raises err.
module tff_bank_rr_sched #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    tff_bank_rr_sched_if.slave   io_bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  r_grant;
    logic [IDXW-1:0]  r_sel;
    logic [PW-1:0]    r_ptr;
    logic [NBITS-1:0] r_q;
    logic [15:0]      r_cnt;

    logic [NREQ-1:0]  w_elig;
    logic [NREQ-1:0]  w_win_oh;
    logic [IDXW-1:0]  w_win_sel;
    logic [PW-1:0]    w_ptr_nxt;
    logic [PW-1:0]    w_idx;
    logic             w_found;
    logic             w_sel_ok;
    logic [NBITS-1:0] w_t_pulse;
    logic             w_err;

    // Pick the first eligible requester at or after the pointer, wrapping.
    // The requester currently holding the grant is masked out.
    always_comb begin
        w_elig    = io_bus.req & ~r_grant;
        w_found   = 1'b0;
        w_win_oh  = '0;
        w_ptr_nxt = r_ptr;
        w_idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && w_elig[w_idx]) begin
                w_found   = 1'b1;
                w_win_oh  = NREQ'(1) << w_idx;
                w_ptr_nxt = PW'((int'(w_idx) + 1) % NREQ);
            end
        end
    end

    // Mux out the bit-select of the winning requester.
    always_comb begin
        w_win_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win_oh[i]) begin
                w_win_sel = io_bus.req_sel[i*IDXW +: IDXW];
            end
        end
    end

    // Decode the captured select into a T strobe, or flag it out of range.
    always_comb begin
        w_sel_ok  = {1'b0, r_sel} < (IDXW+1)'(NBITS);
        w_t_pulse = '0;
        w_err     = 1'b0;
        if (r_grant != '0) begin
            if (w_sel_ok) begin
                w_t_pulse = NBITS'(1) << r_sel;
            end else begin
                w_err = 1'b1;
            end
        end
    end

    // Register grant, captured select and pointer. en low only blocks new grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else if (io_bus.en && w_found) begin
            r_grant <= w_win_oh;
            r_sel   <= w_win_sel;
            r_ptr   <= w_ptr_nxt;
        end else begin
            r_grant <= '0;
        end
    end

    // Toggle bank and saturating toggle counter. A pending strobe completes even with en low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            r_cnt <= '0;
        end else begin
            r_q <= r_q ^ w_t_pulse;
            if ((w_t_pulse != '0) && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign io_bus.grant      = r_grant;
    assign io_bus.t_pulse    = w_t_pulse;
    assign io_bus.q          = r_q;
    assign io_bus.toggle_cnt = r_cnt;
    assign io_bus.err        = w_err;
endmodule
